uart_tx_arbiter: RTL and testbench

Shares the single byte-wide UART transmitter between several on-chip requesters: the control FSM's status reports, the command echo path and the periodic heartbeat. Grants the transmitter round-robin, serialises each requester's bytes into tx_start/tx_data pulses, and holds the grant across multi-byte frames. A watchdog releases the grant if the transmitter never reports completion. Sits between the requesters and the UART TX core.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between N_REQ requesters.
// Holds the grant across multi-byte frames; a watchdog drops the grant if tx_done never comes.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic               timeout_err,
    output logic               idle
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    // StAck/StRelatch are the ack cycle and the following cycle in which the owner's
    // next byte (now updated by the requester) is sampled.
    typedef enum logic [2:0] {StIdle, StStart, StWaitDone, StAck, StRelatch} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               last_q, last_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   ptr_inc;

    // First pending requester at or after ptr, wrapping around.
    always_comb begin
        int unsigned      j;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            cand = IDX_W'(j);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign ptr_inc = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        timeout_d  = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d      = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    tx_data_d    = req_data[{sel, 3'b000} +: 8];
                    last_d       = req_last[sel];
                    state_d      = StStart;
                end
            end
            StStart: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StWaitDone;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_q + 1'b1;
                if (tx_done) begin
                    ack_d[owner_q] = 1'b1;
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = ptr_inc;
                        state_d = StIdle;
                    end else begin
                        state_d = StAck;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    ptr_d     = ptr_inc;
                    state_d   = StIdle;
                end
            end
            StAck: begin
                state_d = StRelatch;
            end
            StRelatch: begin
                if (req[owner_q]) begin
                    tx_data_d = req_data[{owner_q, 3'b000} +: 8];
                    last_d    = req_last[owner_q];
                    state_d   = StStart;
                end else begin
                    grant_d = '0;
                    ptr_d   = ptr_inc;
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack         = ack_q;
    assign grant       = grant_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = timeout_q;
    assign idle        = (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, frames, busy hold-off,
// watchdog, reset mid-frame and round-robin order.
module tb_uart_tx_arbiter;

    logic        in_clk;
    logic        in_rst;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  ack;
    logic [2:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic        timeout_err;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .N_REQ       (3),
        .TIMEOUT_CYC (50),
        .CNT_W       (17)
    ) dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .ack         (ack),
        .grant       (grant),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .timeout_err (timeout_err),
        .idle        (idle)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic wait_start(output bit seen, output logic [7:0] data, output logic [2:0] gnt);
        seen = 1'b0;
        data = 8'hxx;
        gnt  = 3'bxxx;
        for (int i = 0; i < 100; i++) begin
            @(negedge in_clk);
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                data = tx_data;
                gnt  = grant;
                return;
            end
        end
    endtask

    // Raise tx_done d cycles after the current one; returns in the ack cycle.
    task automatic pulse_done(input int d);
        repeat (d) @(negedge in_clk);
        tx_done = 1'b1;
        @(negedge in_clk);
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        in_rst = 1'b0; req = '0; req_data = '0; req_last = '0; tx_busy = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge in_clk);
        n_checks++;
        if ({ack, grant, tx_start, tx_data, timeout_err, idle} !== {3'b0, 3'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: ack=%b grant=%b start=%b data=%h to=%b idle=%b, want 0/0/0/00/0/1",
                     ack, grant, tx_start, tx_data, timeout_err, idle);
        end
        in_rst = 1'b1;
        @(negedge in_clk);
        n_checks++;
        if (idle !== 1'b1 || grant !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: idle=%b grant=%b, want 1/000", idle, grant);
        end
    endtask

    task automatic test_single_byte();
        bit seen; logic [7:0] d; logic [2:0] g;
        req = 3'b001; req_data[7:0] = 8'hA5; req_last = 3'b001;
        @(negedge in_clk);
        n_checks++;
        if (grant !== 3'b001 || tx_data !== 8'hA5 || tx_start !== 1'b0 || idle !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b data=%h start=%b idle=%b, want 001/a5/0/0",
                     grant, tx_data, tx_start, idle);
        end
        @(negedge in_clk);
        n_checks++;
        if (tx_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start_latency: tx_start=%b, want 1", tx_start);
        end
        @(negedge in_clk);
        n_checks++;
        if (tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start_pulse: tx_start=%b, want 0", tx_start);
        end
        pulse_done(9);
        n_checks++;
        if (ack !== 3'b001 || grant !== 3'b000 || idle !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b grant=%b idle=%b to=%b, want 001/000/1/0",
                     ack, grant, idle, timeout_err);
        end
        req = 3'b000;
        @(negedge in_clk);
        n_checks++;
        if (ack !== 3'b000) begin
            n_fail++;
            $display("FAIL single_ack_pulse: ack=%b, want 000", ack);
        end
        seen = 1'b0; d = '0; g = '0;
    endtask

    task automatic test_frame();
        bit seen; logic [7:0] d; logic [2:0] g;
        logic [7:0] bytes [3];
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        req = 3'b010; req_data[15:8] = bytes[0]; req_last = 3'b000;
        for (int b = 0; b < 3; b++) begin
            wait_start(seen, d, g);
            n_checks++;
            if (seen !== 1'b1 || d !== bytes[b] || g !== 3'b010) begin
                n_fail++;
                $display("FAIL frame_byte%0d: seen=%b data=%h grant=%b, want 1/%h/010",
                         b, seen, d, g, bytes[b]);
            end
            if (b == 0) begin
                req[0] = 1'b1; req_data[7:0] = 8'h77; req_last[0] = 1'b1;
            end
            pulse_done(3);
            n_checks++;
            if (ack !== 3'b010 || (b < 2 && (grant !== 3'b010 || idle !== 1'b0))) begin
                n_fail++;
                $display("FAIL frame_ack%0d: ack=%b grant=%b idle=%b, want 010 with grant held",
                         b, ack, grant, idle);
            end
            if (b < 2) begin
                req_data[15:8] = bytes[b + 1];
                req_last[1]    = (b == 1);
            end else begin
                req[1] = 1'b0;
            end
        end
        wait_start(seen, d, g);
        n_checks++;
        if (seen !== 1'b1 || d !== 8'h77 || g !== 3'b001) begin
            n_fail++;
            $display("FAIL frame_next_owner: seen=%b data=%h grant=%b, want 1/77/001", seen, d, g);
        end
        pulse_done(3);
        req = 3'b000;
    endtask

    task automatic test_busy_holdoff();
        bit seen; logic [7:0] d; logic [2:0] g;
        int early;
        early = 0;
        tx_busy = 1'b1;
        req = 3'b010; req_data[15:8] = 8'hB1; req_last = 3'b010;
        for (int i = 0; i < 21; i++) begin
            @(negedge in_clk);
            if (tx_start === 1'b1) early++;
        end
        n_checks++;
        if (early !== 0 || grant !== 3'b010) begin
            n_fail++;
            $display("FAIL busy_no_start: starts=%0d grant=%b, want 0/010", early, grant);
        end
        tx_busy = 1'b0;
        @(negedge in_clk);
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hB1) begin
            n_fail++;
            $display("FAIL busy_release_start: tx_start=%b data=%h, want 1/b1", tx_start, tx_data);
        end
        early = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge in_clk);
            if (timeout_err === 1'b1) early++;
        end
        tx_done = 1'b1;
        @(negedge in_clk);
        tx_done = 1'b0;
        n_checks++;
        if (early !== 0 || timeout_err !== 1'b0 || ack !== 3'b010) begin
            n_fail++;
            $display("FAIL busy_no_timeout: timeouts=%0d to=%b ack=%b, want 0/0/010",
                     early, timeout_err, ack);
        end
        req = 3'b000;
        seen = 1'b0; d = '0; g = '0;
    endtask

    task automatic test_timeout();
        bit seen; logic [7:0] d; logic [2:0] g;
        int early;
        req = 3'b101; req_data[23:16] = 8'hC2; req_data[7:0] = 8'hC0; req_last = 3'b101;
        wait_start(seen, d, g);
        n_checks++;
        if (seen !== 1'b1 || g !== 3'b100 || d !== 8'hC2) begin
            n_fail++;
            $display("FAIL timeout_owner: seen=%b grant=%b data=%h, want 1/100/c2", seen, g, d);
        end
        early = 0;
        for (int i = 0; i < 49; i++) begin
            @(negedge in_clk);
            if (timeout_err === 1'b1 || ack !== 3'b000) early++;
        end
        n_checks++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL timeout_early: events=%0d, want 0", early);
        end
        @(negedge in_clk);
        n_checks++;
        if (timeout_err !== 1'b1 || ack !== 3'b000 || grant !== 3'b000 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_abort: to=%b ack=%b grant=%b idle=%b, want 1/000/000/1",
                     timeout_err, ack, grant, idle);
        end
        @(negedge in_clk);
        n_checks++;
        if (grant !== 3'b001 || tx_data !== 8'hC0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_next: grant=%b data=%h to=%b, want 001/c0/0",
                     grant, tx_data, timeout_err);
        end
        wait_start(seen, d, g);
        pulse_done(3);
        req[0] = 1'b0;
        wait_start(seen, d, g);
        n_checks++;
        if (seen !== 1'b1 || g !== 3'b100) begin
            n_fail++;
            $display("FAIL timeout_rearb: seen=%b grant=%b, want 1/100", seen, g);
        end
        pulse_done(3);
        req = 3'b000;

        // tx_done landing on the watchdog's final cycle must win.
        req = 3'b010; req_data[15:8] = 8'hD1; req_last = 3'b010;
        wait_start(seen, d, g);
        pulse_done(49);
        n_checks++;
        if (ack !== 3'b010 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL done_beats_timeout: ack=%b to=%b, want 010/0", ack, timeout_err);
        end
        req = 3'b000;
        @(negedge in_clk);
        n_checks++;
        if (timeout_err !== 1'b0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL done_beats_timeout_late: to=%b idle=%b, want 0/1", timeout_err, idle);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen; logic [7:0] d; logic [2:0] g;
        req = 3'b100; req_data[23:16] = 8'hE2; req_last = 3'b110; req_data[15:8] = 8'hE1;
        wait_start(seen, d, g);
        n_checks++;
        if (seen !== 1'b1 || g !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_owner: seen=%b grant=%b, want 1/100", seen, g);
        end
        repeat (3) @(negedge in_clk);
        req[1] = 1'b1;
        repeat (2) @(negedge in_clk);
        in_rst = 1'b0;
        #1;
        n_checks++;
        if (grant !== 3'b000 || tx_start !== 1'b0 || idle !== 1'b1 || ack !== 3'b000 ||
            tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_async: grant=%b start=%b idle=%b ack=%b data=%h, want 000/0/1/000/00",
                     grant, tx_start, idle, ack, tx_data);
        end
        @(negedge in_clk);
        in_rst = 1'b1;
        @(negedge in_clk);
        n_checks++;
        if (grant !== 3'b010 || tx_data !== 8'hE1) begin
            n_fail++;
            $display("FAIL rstmid_ptr0: grant=%b data=%h, want 010/e1", grant, tx_data);
        end
        wait_start(seen, d, g);
        pulse_done(3);
        req[1] = 1'b0;
        wait_start(seen, d, g);
        n_checks++;
        if (seen !== 1'b1 || g !== 3'b100 || d !== 8'hE2) begin
            n_fail++;
            $display("FAIL rstmid_rearb: seen=%b grant=%b data=%h, want 1/100/e2", seen, g, d);
        end
        pulse_done(3);
        req = 3'b000;
    endtask

    task automatic test_round_robin();
        bit seen; logic [7:0] d; logic [2:0] g;
        logic [2:0] exp_g;
        req = 3'b111; req_last = 3'b111; req_data = 24'h12_11_10;
        for (int i = 0; i < 6; i++) begin
            exp_g = 3'b001 << (i % 3);
            wait_start(seen, d, g);
            n_checks++;
            if (seen !== 1'b1 || g !== exp_g || d !== 8'h10 + 8'(i % 3)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: seen=%b grant=%b data=%h, want 1/%b/%h",
                         i, seen, g, d, exp_g, 8'h10 + 8'(i % 3));
            end
            pulse_done(2);
            n_checks++;
            if (ack !== exp_g) begin
                n_fail++;
                $display("FAIL rr_ack%0d: ack=%b, want %b", i, ack, exp_g);
            end
        end
        req = 3'b000;
        repeat (2) @(negedge in_clk);
        n_checks++;
        if (idle !== 1'b1 || grant !== 3'b000) begin
            n_fail++;
            $display("FAIL rr_final_idle: idle=%b grant=%b, want 1/000", idle, grant);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_frame();
        test_busy_holdoff();
        test_timeout();
        test_reset_mid_frame();
        test_round_robin();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
